cpu_core: RTL and testbench



---
 rtl/cpu_core_pkg.sv | 64 ++++++
 rtl/cpu_core_cu.sv | 61 ++++++
 rtl/cpu_core_imem.sv | 28 ++
 rtl/cpu_core_regfile.sv | 37 +++
 rtl/cpu_core.sv | 120 ++++++++++++
 tb/tb_cpu_core.sv | 177 +++++++++++++++++
 6 files changed

// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: shared definitions for the 18-bit single-cycle core.
//   Opcode values, instruction field bit positions, datapath width,
//   register count, ALU operation encoding, the decoded control struct
//   and the immediate sign-extension helper.
package cpu_core_pkg;

  localparam int DATA_W   = 18;
  localparam int NUM_REGS = 16;
  localparam int REG_AW   = 4;
  localparam int OP_W     = 4;
  localparam int IMM_W    = 6;
  localparam int TGT_W    = 10;

  // Instruction field positions
  localparam int OP_HI  = 17;
  localparam int OP_LO  = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 2;
  localparam int IMM_HI = 5;
  localparam int TGT_HI = 9;

  // Opcodes; anything not listed decodes as NOP
  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_AND  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
  localparam logic [OP_W-1:0] OP_OR   = 4'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd5;
  localparam logic [OP_W-1:0] OP_ANDI = 4'd8;
  localparam logic [OP_W-1:0] OP_ADDI = 4'd9;
  localparam logic [OP_W-1:0] OP_LD   = 4'd10;
  localparam logic [OP_W-1:0] OP_ST   = 4'd11;
  localparam logic [OP_W-1:0] OP_JUMP = 4'd12;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'd13;
  localparam logic [OP_W-1:0] OP_BNE  = 4'd14;
  localparam logic [OP_W-1:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    ALU_AND,
    ALU_ADD,
    ALU_SUB,
    ALU_OR,
    ALU_XOR
  } alu_op_e;

  // Datapath steering; branch and pc_write are kept as separate signals
  typedef struct packed {
    logic    reg_write;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src_imm;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_core_cu.sv
// cpu_core_cu: control unit. Pure combinational decode of the opcode plus
// the rd==rs1 compare result into datapath controls.
//   opcode      in  4  instruction opcode
//   operands_eq in  1  rd value equals rs1 value
//   ctrl        out    register/memory/ALU steering
//   branch      out 1  take the branch/jump target this cycle
//   pc_write    out 1  PC advances this cycle
// Macro CPU_CORE_HALT_EN: when defined, opcode 15 freezes the PC.
module cpu_core_cu
  import cpu_core_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  input  logic            operands_eq,
  output ctrl_t           ctrl,
  output logic            branch,
  output logic            pc_write
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALU_ADD;
    branch      = 1'b0;
    pc_write    = 1'b1;
    case (opcode)
      OP_AND:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_AND; end
      OP_ADD:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
      OP_SUB:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
      OP_OR:   begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_OR;  end
      OP_XOR:  begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_XOR; end
      OP_ANDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_op      = ALU_AND;
      end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_LD: begin
        ctrl.reg_write   = 1'b1;
        ctrl.mem_to_reg  = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_ST: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
      end
      OP_JUMP: begin
        ctrl.jump = 1'b1;
        branch    = 1'b1;
      end
      OP_BEQ:  branch = operands_eq;
      OP_BNE:  branch = !operands_eq;
`ifdef CPU_CORE_HALT_EN
      OP_HALT: pc_write = 1'b0;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_core_imem.sv
// cpu_core_imem: instruction memory, combinational read. The write port
// exists for program loading; the core ties it off and programs are
// normally preloaded. Contents are not affected by reset.
//   addr/instr       fetch port
//   we/waddr/wdata   load port, rising edge
module cpu_core_imem
  import cpu_core_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     addr,
  output logic [DATA_W-1:0] instr
);

  logic [DATA_W-1:0] instr_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) instr_mem[waddr] <= wdata;
  end

  assign instr = instr_mem[addr];

endmodule

// File: rtl/cpu_core_regfile.sv
// cpu_core_regfile: 16 x 18-bit register file, three async read ports
// (rs1, rs2, rd) and one write port. R0 always reads 0 and ignores writes.
// Reads see the pre-edge value during a same-cycle write.
//   clk, reset   sync active-high reset clears every register
//   we/waddr/wdata  write port, commits on rising edge
//   ra*/rd*      read address / data pairs
module cpu_core_regfile
  import cpu_core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3
);

  logic [DATA_W-1:0] registers [0:NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) registers[i] <= '0;
    end else if (we && waddr != '0) begin
      registers[waddr] <= wdata;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : registers[ra1];
  assign rd2 = (ra2 == '0) ? '0 : registers[ra2];
  assign rd3 = (ra3 == '0) ? '0 : registers[ra3];

endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 18-bit load/store processor. Fetch, decode and
// execute are combinational from program_counter; register write, data
// memory write and PC update commit together on the rising edge.
//   clk            sole clock
//   reset          synchronous, active-high; PC and registers to 0
//   debug_opcode   current_instr[17:14]
//   debug_pc_write control-unit pc_write
//   debug_branch   control-unit branch
// Macro CPU_CORE_HALT_EN: opcode 15 halts the PC until reset.
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            reset,
  output logic [OP_W-1:0] debug_opcode,
  output logic            debug_pc_write,
  output logic            debug_branch
);

  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int DA_W = $clog2(DMEM_DEPTH);

  logic [PC_W-1:0]   program_counter, pc_next, pc_plus1, br_target;
  logic [DATA_W-1:0] current_instr;
  logic [OP_W-1:0]   opcode;
  logic [REG_AW-1:0] rd_a, rs1_a, rs2_a;
  logic [DATA_W-1:0] imm, rs1_val, rs2_val, rd_val;
  logic [DATA_W-1:0] alu_b, alu_result, wb_data, dmem_rdata;
  logic [DA_W-1:0]   dmem_addr;
  ctrl_t             ctrl;
  logic              branch, pc_write;

  logic [DATA_W-1:0] dmem [0:DMEM_DEPTH-1];

  cpu_core_imem #(.DEPTH(IMEM_DEPTH), .AW(PC_W)) my_instr_memory (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .addr  (program_counter),
    .instr (current_instr)
  );

  assign opcode = current_instr[OP_HI:OP_LO];
  assign rd_a   = current_instr[RD_HI:RD_LO];
  assign rs1_a  = current_instr[RS1_HI:RS1_LO];
  assign rs2_a  = current_instr[RS2_HI:RS2_LO];
  assign imm    = sext_imm(current_instr[IMM_HI:0]);

  // rd is also a source: store data and the BEQ/BNE left operand
  cpu_core_regfile my_reg_file (
    .clk   (clk),
    .reset (reset),
    .we    (ctrl.reg_write),
    .waddr (rd_a),
    .wdata (wb_data),
    .ra1   (rs1_a),
    .ra2   (rs2_a),
    .ra3   (rd_a),
    .rd1   (rs1_val),
    .rd2   (rs2_val),
    .rd3   (rd_val)
  );

  cpu_core_cu my_cu (
    .opcode      (opcode),
    .operands_eq (rd_val == rs1_val),
    .ctrl        (ctrl),
    .branch      (branch),
    .pc_write    (pc_write)
  );

  assign alu_b = ctrl.alu_src_imm ? imm : rs2_val;

  always_comb begin
    alu_result = '0;
    case (ctrl.alu_op)
      ALU_AND: alu_result = rs1_val & alu_b;
      ALU_ADD: alu_result = rs1_val + alu_b;
      ALU_SUB: alu_result = rs1_val - alu_b;
      ALU_OR:  alu_result = rs1_val | alu_b;
      ALU_XOR: alu_result = rs1_val ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  // Data memory: address from the low bits of rs1+imm, async read
  assign dmem_addr  = alu_result[DA_W-1:0];
  assign dmem_rdata = dmem[dmem_addr];

  always_ff @(posedge clk) begin
    if (!reset && ctrl.mem_write) dmem[dmem_addr] <= rd_val;
  end

  assign wb_data = ctrl.mem_to_reg ? dmem_rdata : alu_result;

  // PC arithmetic is PC_W bits wide so it wraps at IMEM_DEPTH naturally
  assign pc_plus1  = program_counter + PC_W'(1);
  assign br_target = ctrl.jump ? PC_W'(current_instr[TGT_HI:0])
                               : pc_plus1 + PC_W'(imm);

  always_comb begin
    pc_next = pc_plus1;
    if (!pc_write)   pc_next = program_counter;
    else if (branch) pc_next = br_target;
  end

  always_ff @(posedge clk) begin
    if (reset) program_counter <= '0;
    else       program_counter <= pc_next;
  end

  assign debug_opcode   = opcode;
  assign debug_pc_write = pc_write;
  assign debug_branch   = branch;

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed self-checking bench for cpu_core. Programs are
// poked into instruction memory hierarchically, then the core is stepped
// one clock at a time and state is checked on the falling edge.
module tb_cpu_core;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] debug_opcode;
  logic       debug_pc_write;
  logic       debug_branch;

  int tests = 0;
  int fails = 0;

  cpu_core dut (
    .clk            (clk),
    .reset          (reset),
    .debug_opcode   (debug_opcode),
    .debug_pc_write (debug_pc_write),
    .debug_branch   (debug_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] enc_r(input int op, input int rd, input int rs1, input int rs2);
    return {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], 2'b00};
  endfunction

  function automatic logic [17:0] enc_i(input int op, input int rd, input int rs1, input int imm);
    return {op[3:0], rd[3:0], rs1[3:0], imm[5:0]};
  endfunction

  function automatic logic [17:0] enc_j(input int op, input int tgt);
    return {op[3:0], 4'd0, tgt[9:0]};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) dut.my_instr_memory.instr_mem[i] = '0;
  endtask

  // Advance exactly one rising edge, landing on the next falling edge
  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pc();
    return 32'(dut.program_counter);
  endfunction

  function automatic logic [31:0] rg(input int i);
    return 32'(dut.my_reg_file.registers[i]);
  endfunction

  initial begin
    clear_imem();

    // Reset held three cycles
    reset = 1'b1;
    step(); step(); step();
    chk("reset_pc", pc(), 32'd0);
    chk("reset_opcode", 32'(debug_opcode), 32'd0);
    for (int i = 1; i < 16; i++) chk($sformatf("reset_r%0d", i), rg(i), 32'd0);

    // Empty memory: NOPs, PC free-runs
    reset = 1'b0;
    step(); chk("freerun_pc1", pc(), 32'd1);
    step(); chk("freerun_pc2", pc(), 32'd2);
    step(); chk("freerun_pc3", pc(), 32'd3);
    chk("freerun_pc_write", 32'(debug_pc_write), 32'd1);

    // ADD R0,R0,R1 then ADDI R0,R0,0: R0 writes discarded
    clear_imem();
    dut.my_instr_memory.instr_mem[0] = 18'h08004;
    dut.my_instr_memory.instr_mem[1] = 18'h24000;
    do_reset();
    chk("add_op", 32'(debug_opcode), 32'd2);
    chk("add_pcw", 32'(debug_pc_write), 32'd1);
    chk("add_br", 32'(debug_branch), 32'd0);
    step();
    for (int i = 0; i < 4; i++) chk($sformatf("add_r%0d", i), rg(i), 32'd0);
    chk("addi_op", 32'(debug_opcode), 32'd9);
    chk("addi_pcw", 32'(debug_pc_write), 32'd1);
    chk("addi_br", 32'(debug_branch), 32'd0);
    step();
    chk("addi_pc", pc(), 32'd2);

    // Arithmetic and a self-loop BEQ
    clear_imem();
    dut.my_instr_memory.instr_mem[0] = enc_i(9, 1, 0, 10);    // ADDI R1,R0,#10
    dut.my_instr_memory.instr_mem[1] = enc_r(2, 3, 1, 1);     // ADD  R3,R1,R1
    dut.my_instr_memory.instr_mem[2] = enc_r(3, 2, 0, 1);     // SUB  R2,R0,R1
    dut.my_instr_memory.instr_mem[3] = enc_i(13, 1, 1, -1);   // BEQ  R1,R1,#-1
    do_reset();
    step(); chk("arith_r1", rg(1), 32'd10);
    step(); chk("arith_r3", rg(3), 32'd20);
    step(); chk("arith_r2", rg(2), 32'h3FFF6);
    chk("beq_pc", pc(), 32'd3);
    chk("beq_op", 32'(debug_opcode), 32'd13);
    chk("beq_br", 32'(debug_branch), 32'd1);
    step(); chk("beq_hold1", pc(), 32'd3);
    step(); chk("beq_hold2", pc(), 32'd3);

    // BNE not taken, store/load, taken BEQ skip, jump and PC wrap
    clear_imem();
    dut.my_instr_memory.instr_mem[0] = enc_i(9, 1, 0, 10);    // ADDI R1,R0,#10
    dut.my_instr_memory.instr_mem[1] = enc_i(14, 1, 1, 5);    // BNE  R1,R1,#5
    dut.my_instr_memory.instr_mem[2] = enc_i(11, 1, 0, 5);    // ST   R1,[R0+5]
    dut.my_instr_memory.instr_mem[3] = enc_i(10, 4, 0, 5);    // LD   R4,[R0+5]
    dut.my_instr_memory.instr_mem[4] = enc_i(13, 4, 1, 2);    // BEQ  R4,R1,#2
    dut.my_instr_memory.instr_mem[5] = enc_i(9, 5, 1, 1);     // ADDI R5,R1,#1 (skipped)
    dut.my_instr_memory.instr_mem[7] = enc_j(12, 10'h3FF);    // JUMP 0x3FF
    do_reset();
    step();
    chk("bne_pc", pc(), 32'd1);
    chk("bne_br", 32'(debug_branch), 32'd0);
    step(); chk("bne_next_pc", pc(), 32'd2);
    step();
    chk("st_pc", pc(), 32'd3);
    chk("st_mem", 32'(dut.dmem[5]), 32'd10);
    step();
    chk("ld_r4", rg(4), 32'd10);
    chk("beq2_br", 32'(debug_branch), 32'd1);
    step();
    chk("beq2_pc", pc(), 32'd7);
    chk("skip_r5", rg(5), 32'd0);
    chk("jump_br", 32'(debug_branch), 32'd1);
    step(); chk("jump_pc", pc(), 32'h3FF);
    step(); chk("wrap_pc", pc(), 32'd0);

    // HALT
    clear_imem();
    dut.my_instr_memory.instr_mem[0] = enc_j(15, 0);
    do_reset();
    chk("halt_op", 32'(debug_opcode), 32'd15);
`ifdef CPU_CORE_HALT_EN
    chk("halt_pcw", 32'(debug_pc_write), 32'd0);
    step(); chk("halt_pc1", pc(), 32'd0);
    step(); chk("halt_pc2", pc(), 32'd0);
`else
    chk("halt_pcw", 32'(debug_pc_write), 32'd1);
    step(); chk("halt_pc1", pc(), 32'd1);
    step(); chk("halt_pc2", pc(), 32'd2);
`endif

    // Reset mid-run wins over a pending register write
    clear_imem();
    dut.my_instr_memory.instr_mem[5] = enc_i(9, 7, 0, 7);     // ADDI R7,R0,#7
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("mid_pc", pc(), 32'd5);
    chk("mid_op", 32'(debug_opcode), 32'd9);
    reset = 1'b1;
    step();
    chk("mid_reset_pc", pc(), 32'd0);
    chk("mid_reset_r7", rg(7), 32'd0);
    reset = 1'b0;
    step(); chk("after_reset_pc", pc(), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
